// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between instruction fetch and the MEM stage.
// A one-entry fetch buffer lets a held PC hit without a new bus transaction.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_inst_o,
  output logic              stallreq_if_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              stallreq_mem_o,
  input  logic              flush_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_sel_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic [DATA_W-1:0] bus_rdata_i,
  input  logic              bus_ack_i
);

  localparam int WORD_W = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_IF_WAIT  = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_MEM_DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                issue_mem_s;
  logic                issue_if_s;
  logic                if_ack_s;
  logic                mem_ack_s;
  logic                hit_s;
  logic                mem_done_s;
  logic                store_hit_s;
  logic                unused_s;

  logic                bus_req_r;
  logic                bus_we_r;
  logic [3:0]          bus_sel_r;
  logic [ADDR_W-1:0]   bus_addr_r;
  logic [DATA_W-1:0]   bus_wdata_r;

  logic                buf_valid_r;
  logic [WORD_W-1:0]   buf_addr_r;
  logic [DATA_W-1:0]   buf_inst_r;
  logic [DATA_W-1:0]   mem_rdata_r;

  // Byte offset of the fetch address never matters: the buffer is word-indexed.
  assign unused_s    = ^if_addr_i[1:0];

  assign hit_s       = buf_valid_r && (buf_addr_r == if_addr_i[ADDR_W-1:2]);
  assign mem_done_s  = (state_r == ST_MEM_DONE);
  assign store_hit_s = mem_ack_s && bus_we_r && (bus_addr_r[ADDR_W-1:2] == buf_addr_r);

  assign stallreq_if_o  = if_ce_i && !hit_s;
  assign if_inst_o      = hit_s ? buf_inst_r : {DATA_W{1'b0}};
  assign stallreq_mem_o = mem_ce_i && !mem_done_s;
  assign mem_data_o     = (mem_done_s && !mem_we_i) ? mem_rdata_r : {DATA_W{1'b0}};

  assign bus_req_o   = bus_req_r;
  assign bus_we_o    = bus_we_r;
  assign bus_sel_o   = bus_sel_r;
  assign bus_addr_o  = bus_addr_r;
  assign bus_wdata_o = bus_wdata_r;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and arbitration; MEM wins ties and only IDLE arbitrates.
  always_comb begin
    state_s     = state_r;
    issue_mem_s = 1'b0;
    issue_if_s  = 1'b0;
    if_ack_s    = 1'b0;
    mem_ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (mem_ce_i && !mem_done_s) begin
          issue_mem_s = 1'b1;
          state_s     = ST_MEM_WAIT;
        end else if (if_ce_i && !hit_s) begin
          issue_if_s = 1'b1;
          state_s    = ST_IF_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_IF_WAIT: begin
        if (bus_ack_i && bus_req_r) begin
          if_ack_s = 1'b1;
          state_s  = ST_IDLE;
        end else begin
          state_s = ST_IF_WAIT;
        end
      end
      ST_MEM_WAIT: begin
        if (bus_ack_i && bus_req_r) begin
          mem_ack_s = 1'b1;
          state_s   = ST_MEM_DONE;
        end else begin
          state_s = ST_MEM_WAIT;
        end
      end
      ST_MEM_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Bus request registers; held stable from issue until the ack edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_req_r   <= 1'b0;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'h0;
      bus_addr_r  <= {ADDR_W{1'b0}};
      bus_wdata_r <= {DATA_W{1'b0}};
    end else if (issue_mem_s) begin
      bus_req_r   <= 1'b1;
      bus_we_r    <= mem_we_i;
      bus_sel_r   <= mem_sel_i;
      bus_addr_r  <= mem_addr_i;
      bus_wdata_r <= mem_data_i;
    end else if (issue_if_s) begin
      bus_req_r   <= 1'b1;
      bus_we_r    <= 1'b0;
      bus_sel_r   <= 4'hF;
      bus_addr_r  <= if_addr_i;
      bus_wdata_r <= {DATA_W{1'b0}};
    end else if (if_ack_s || mem_ack_s) begin
      bus_req_r <= 1'b0;
    end
  end

  // Fetch buffer and load-data capture; flush beats a same-cycle fetch fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_valid_r <= 1'b0;
      buf_addr_r  <= {WORD_W{1'b0}};
      buf_inst_r  <= {DATA_W{1'b0}};
      mem_rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (if_ack_s) begin
        buf_inst_r <= bus_rdata_i;
        buf_addr_r <= bus_addr_r[ADDR_W-1:2];
      end
      if (flush_i) begin
        buf_valid_r <= 1'b0;
      end else if (if_ack_s) begin
        buf_valid_r <= 1'b1;
      end else if (store_hit_s) begin
        buf_valid_r <= 1'b0;
      end
      if (mem_ack_s && !bus_we_r) begin
        mem_rdata_r <= bus_rdata_i;
      end
    end
  end

endmodule
